// File: rtl/lcd_char_pkg.sv
// Shared constants, state encoding and helpers for the character LCD controller.
package lcd_char_pkg;

  // HD44780 command bytes
  localparam logic [7:0] FUNC_4BIT_1L = 8'h20;
  localparam logic [7:0] FUNC_4BIT_2L = 8'h28;
  localparam logic [7:0] DISP_ON      = 8'h0C;
  localparam logic [7:0] CLEAR        = 8'h01;
  localparam logic [7:0] ENTRY_INC    = 8'h06;
  localparam logic [7:0] SET_DDRAM    = 8'h80;

  // Reset-to-4-bit wake-up nibbles
  localparam logic [3:0] INIT_NIB_8BIT = 4'h3;
  localparam logic [3:0] INIT_NIB_4BIT = 4'h2;

  typedef enum logic [3:0] {
    ST_PWRUP_WAIT,
    ST_INIT,
    ST_FUNC,
    ST_DISP_ON,
    ST_CLEAR,
    ST_CLEAR_WAIT,
    ST_ENTRY,
    ST_SET_ADDR,
    ST_CHAR
  } state_t;

  // DDRAM base address of each panel row
  function automatic logic [7:0] row_base(input int r);
    case (r)
      0:       return 8'h00;
      1:       return 8'h40;
      2:       return 8'h14;
      default: return 8'h54;
    endcase
  endfunction

  // Bit width needed to hold 0..v-1, never less than one bit
  function automatic int clog2_min1(input int v);
    return (v < 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/lcd_char_ctrl_tick.sv
// One-cycle tick every TICK_DIV clocks; paces all LCD bus activity.
module lcd_tick_gen
  import lcd_char_pkg::*;
#(
  parameter int FREQ    = 100000000,
  parameter int TICK_HZ = 657
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int TICK_DIV = FREQ / TICK_HZ;
  localparam int TW       = clog2_min1(TICK_DIV);

  logic [TW-1:0] cnt;

  assign tick = (cnt == TW'(TICK_DIV - 1));

  // Free-running divider, wraps right after the tick cycle
  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/lcd_char_ctrl.sv
// HD44780 4-bit controller: init sequence, then continuous refresh from a shadow buffer.
module lcd_char_ctrl
  import lcd_char_pkg::*;
#(
  parameter int FREQ        = 100000000,
  parameter int TICK_HZ     = 657,
  parameter int ROWS        = 2,
  parameter int COLS        = 16,
  parameter int PWRUP_TICKS = 12,
  parameter int CLEAR_TICKS = 2,
  localparam int RW = clog2_min1(ROWS),
  localparam int CW = clog2_min1(COLS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_data,
  input  logic [RW-1:0] in_row,
  input  logic [CW-1:0] in_col,
  input  logic          in_clear,
  output logic          init_done,
  output logic          frame_done,
  output logic [3:0]    lcd_data,
  output logic          lcd_en,
  output logic          lcd_rw,
  output logic          lcd_rs
);

  localparam int CELLS = ROWS * COLS;
  localparam int AW    = clog2_min1(CELLS);
  localparam int WW    = clog2_min1(PWRUP_TICKS > CLEAR_TICKS ? PWRUP_TICKS : CLEAR_TICKS);

  logic tick;

  lcd_tick_gen #(.FREQ(FREQ), .TICK_HZ(TICK_HZ)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  logic [7:0]    mem [CELLS];
  state_t        state;
  logic          phase_b;   // next tick ends the nibble (E low)
  logic          lo_half;   // current nibble is the low half of a byte
  logic [1:0]    init_cnt;
  logic [WW-1:0] wait_cnt;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [7:0]    chr;       // character latched at its high nibble
  logic [AW-1:0] clr_idx;
  logic [AW-1:0] rd_idx, wr_idx, mem_wa;
  logic [7:0]    cmd_byte, mem_wd;
  logic [3:0]    nib;
  logic          wr_ok, mem_we;

  assign lcd_rw = 1'b0;
  assign rd_idx = AW'(int'(row) * COLS + int'(col));
  assign wr_idx = AW'(int'(in_row) * COLS + int'(in_col));

  // Byte/nibble currently due on the bus
  always_comb begin
    cmd_byte = 8'h00;
    case (state)
      ST_FUNC:     cmd_byte = (ROWS > 1) ? FUNC_4BIT_2L : FUNC_4BIT_1L;
      ST_DISP_ON:  cmd_byte = DISP_ON;
      ST_CLEAR:    cmd_byte = CLEAR;
      ST_ENTRY:    cmd_byte = ENTRY_INC;
      ST_SET_ADDR: cmd_byte = SET_DDRAM | row_base(int'(row));
      ST_CHAR:     cmd_byte = lo_half ? chr : mem[rd_idx];
      default:     cmd_byte = 8'h00;
    endcase
    if (state == ST_INIT) nib = (init_cnt == 2'd3) ? INIT_NIB_4BIT : INIT_NIB_8BIT;
    else                  nib = lo_half ? cmd_byte[3:0] : cmd_byte[7:4];
  end

  // Refresh FSM: every nibble is an E-high tick followed by an E-low tick
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_PWRUP_WAIT;
      phase_b    <= 1'b0;
      lo_half    <= 1'b0;
      init_cnt   <= '0;
      wait_cnt   <= '0;
      row        <= '0;
      col        <= '0;
      chr        <= 8'h00;
      lcd_data   <= 4'h0;
      lcd_en     <= 1'b0;
      lcd_rs     <= 1'b0;
      init_done  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (tick) begin
        case (state)
          ST_PWRUP_WAIT: begin
            if (wait_cnt == WW'(PWRUP_TICKS - 1)) begin
              wait_cnt <= '0;
              state    <= ST_INIT;
            end else wait_cnt <= wait_cnt + 1'b1;
          end
          ST_CLEAR_WAIT: begin
            if (wait_cnt == WW'(CLEAR_TICKS - 1)) begin
              wait_cnt <= '0;
              state    <= ST_ENTRY;
            end else wait_cnt <= wait_cnt + 1'b1;
          end
          default: begin
            if (!phase_b) begin
              lcd_en   <= 1'b1;
              lcd_data <= nib;
              lcd_rs   <= (state == ST_CHAR);
              phase_b  <= 1'b1;
              // Hold the whole byte so a host write cannot tear it
              if (state == ST_CHAR && !lo_half) chr <= mem[rd_idx];
            end else begin
              lcd_en  <= 1'b0;
              phase_b <= 1'b0;
              if (state == ST_INIT) begin
                init_cnt <= init_cnt + 2'd1;
                if (init_cnt == 2'd3) state <= ST_FUNC;
              end else if (!lo_half) begin
                lo_half <= 1'b1;
              end else begin
                lo_half <= 1'b0;
                case (state)
                  ST_FUNC:    state <= ST_DISP_ON;
                  ST_DISP_ON: state <= ST_CLEAR;
                  ST_CLEAR:   state <= ST_CLEAR_WAIT;
                  ST_ENTRY: begin
                    state     <= ST_SET_ADDR;
                    init_done <= 1'b1;
                    row       <= '0;
                    col       <= '0;
                  end
                  ST_SET_ADDR: begin
                    state <= ST_CHAR;
                    col   <= '0;
                  end
                  ST_CHAR: begin
                    if (col == CW'(COLS - 1)) begin
                      col   <= '0;
                      state <= ST_SET_ADDR;
                      if (row == RW'(ROWS - 1)) begin
                        row        <= '0;
                        frame_done <= 1'b1;
                      end else row <= row + 1'b1;
                    end else col <= col + 1'b1;
                  end
                  default: state <= ST_PWRUP_WAIT;
                endcase
              end
            end
          end
        endcase
      end
    end
  end

  // Clear sweep owns the buffer write port while in_ready is low
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready <= 1'b1;
      clr_idx  <= '0;
    end else if (!in_ready) begin
      clr_idx <= clr_idx + 1'b1;
      if (clr_idx == AW'(CELLS - 1)) in_ready <= 1'b1;
    end else if (in_clear) begin
      in_ready <= 1'b0;
      clr_idx  <= '0;
    end
  end

  // Out-of-range writes are accepted but never reach the buffer; clear beats write
  assign wr_ok  = in_valid && in_ready && !in_clear &&
                  (int'(in_row) < ROWS) && (int'(in_col) < COLS);
  assign mem_we = !rst && (!in_ready || wr_ok);
  assign mem_wa = in_ready ? wr_idx : clr_idx;
  assign mem_wd = in_ready ? in_data : 8'h20;

  // Shadow buffer, deliberately not reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

endmodule

// File: tb/tb_lcd_char_ctrl.sv
// Scoreboard bench: expected LCD nibbles are queued as stimulus is applied and
// checked on every E rising edge; timing of init/frame events checked directly.
module tb_lcd_char_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rst_b;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 2x16 instance
  logic v2, c2, rdy2, id2, fd2, en2, rw2, rs2;
  logic [7:0] d2; logic [0:0] row2; logic [3:0] col2; logic [3:0] lcd2;
  // 4x20 instance
  logic v4, c4, rdy4, id4, fd4, en4, rw4, rs4;
  logic [7:0] d4; logic [1:0] row4; logic [4:0] col4; logic [3:0] lcd4;
  // 1x16 instance
  logic v1, c1, rdy1, id1, fd1, en1, rw1, rs1;
  logic [7:0] d1; logic [0:0] row1; logic [3:0] col1; logic [3:0] lcd1;

  lcd_char_ctrl #(.FREQ(6570), .TICK_HZ(657), .ROWS(2), .COLS(16)) u2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_ready(rdy2), .in_data(d2),
    .in_row(row2), .in_col(col2), .in_clear(c2), .init_done(id2), .frame_done(fd2),
    .lcd_data(lcd2), .lcd_en(en2), .lcd_rw(rw2), .lcd_rs(rs2));

  lcd_char_ctrl #(.FREQ(6570), .TICK_HZ(657), .ROWS(4), .COLS(20)) u4 (
    .clk(clk), .rst(rst_b), .in_valid(v4), .in_ready(rdy4), .in_data(d4),
    .in_row(row4), .in_col(col4), .in_clear(c4), .init_done(id4), .frame_done(fd4),
    .lcd_data(lcd4), .lcd_en(en4), .lcd_rw(rw4), .lcd_rs(rs4));

  lcd_char_ctrl #(.FREQ(6570), .TICK_HZ(657), .ROWS(1), .COLS(16)) u1 (
    .clk(clk), .rst(rst_b), .in_valid(v1), .in_ready(rdy1), .in_data(d1),
    .in_row(row1), .in_col(col1), .in_clear(c1), .init_done(id1), .frame_done(fd1),
    .lcd_data(lcd1), .lcd_en(en1), .lcd_rw(rw1), .lcd_rs(rs1));

  int checks = 0, failures = 0;
  logic [7:0] m2 [32];
  logic [7:0] m4 [80];
  logic [7:0] m1 [16];
  logic [4:0] q2 [$];
  logic [4:0] q4 [$];
  logic [4:0] q1 [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] base(input int r);
    case (r)
      0: return 8'h80;
      1: return 8'hC0;
      2: return 8'h94;
      default: return 8'hD4;
    endcase
  endfunction

  function automatic logic [7:0] mget(input int w, input int i);
    case (w)
      0: return m2[i];
      1: return m4[i];
      default: return m1[i];
    endcase
  endfunction

  task automatic push_n(input int w, input logic rs, input logic [3:0] n);
    case (w)
      0: q2.push_back({rs, n});
      1: q4.push_back({rs, n});
      default: q1.push_back({rs, n});
    endcase
  endtask

  task automatic push_b(input int w, input logic rs, input logic [7:0] b);
    push_n(w, rs, b[7:4]);
    push_n(w, rs, b[3:0]);
  endtask

  task automatic push_init(input int w, input int rows);
    push_n(w, 0, 4'h3); push_n(w, 0, 4'h3); push_n(w, 0, 4'h3); push_n(w, 0, 4'h2);
    push_b(w, 0, (rows > 1) ? 8'h28 : 8'h20);
    push_b(w, 0, 8'h0C);
    push_b(w, 0, 8'h01);
    push_b(w, 0, 8'h06);
  endtask

  task automatic push_frame(input int w, input int rows, input int cols);
    for (int r = 0; r < rows; r++) begin
      push_b(w, 0, base(r));
      for (int c = 0; c < cols; c++) push_b(w, 1, mget(w, r * cols + c));
    end
  endtask

  // Scoreboard: pop one expected nibble per E rising edge while entries are pending
  logic p2 = 0, p4 = 0, p1 = 0;
  always @(negedge clk) begin
    logic [4:0] e;
    if (en2 && !p2 && q2.size() > 0) begin e = q2.pop_front(); chk("u2_nibble", {rs2, lcd2}, e); end
    if (en4 && !p4 && q4.size() > 0) begin e = q4.pop_front(); chk("u4_nibble", {rs4, lcd4}, e); end
    if (en1 && !p1 && q1.size() > 0) begin e = q1.pop_front(); chk("u1_nibble", {rs1, lcd1}, e); end
    p2 <= en2; p4 <= en4; p1 <= en1;
  end

  task automatic wr2(input logic [0:0] r, input logic [3:0] c, input logic [7:0] d);
    v2 = 1; row2 = r; col2 = c; d2 = d; @(negedge clk); v2 = 0;
  endtask
  task automatic wr4(input logic [1:0] r, input logic [4:0] c, input logic [7:0] d);
    v4 = 1; row4 = r; col4 = c; d4 = d; @(negedge clk); v4 = 0;
  endtask
  task automatic wr1(input logic [0:0] r, input logic [3:0] c, input logic [7:0] d);
    v1 = 1; row1 = r; col1 = c; d1 = d; @(negedge clk); v1 = 0;
  endtask

  initial begin
    int rel, n, t;
    rst = 1; rst_b = 1;
    v2 = 0; c2 = 0; d2 = 0; row2 = 0; col2 = 0;
    v4 = 0; c4 = 0; d4 = 0; row4 = 0; col4 = 0;
    v1 = 0; c1 = 0; d1 = 0; row1 = 0; col1 = 0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", rdy2, 1);
    chk("rst_lcd_en", en2, 0);
    chk("rst_lcd_data", lcd2, 0);
    chk("rst_lcd_rs", rs2, 0);
    chk("rst_lcd_rw", rw2, 0);
    chk("rst_init_done", id2, 0);
    chk("rst_frame_done", fd2, 0);

    // Release; clear and a write in the same cycle (clear must win)
    rst = 0; rel = cyc;
    c2 = 1; v2 = 1; d2 = 8'h5A; row2 = 0; col2 = 3;
    push_init(0, 2);
    @(negedge clk); c2 = 0; v2 = 0;
    for (int i = 0; i < 32; i++) m2[i] = 8'h20;
    n = 0;
    while (!rdy2 && n < 100) begin n++; @(negedge clk); end
    chk("u2_clear_ready_low", n, 32);
    chk("u2_ready_before_write", rdy2, 1);
    wr2(0, 15, 8'h7E); m2[15] = 8'h7E;
    wr2(1, 0, 8'h41);  m2[16] = 8'h41;
    push_frame(0, 2, 16);

    n = 0; do begin @(negedge clk); n++; end while (!en2 && n < 300);
    chk("u2_first_en_cycle", cyc - rel, 130);
    n = 0; do begin @(negedge clk); n++; end while (!id2 && n < 500);
    chk("u2_init_done_cycle", cyc - rel, 380);
    n = 0; do begin @(negedge clk); n++; end while (!fd2 && n < 2000);
    chk("u2_frame1_cycle", cyc - rel, 1740);
    t = cyc;
    @(negedge clk);
    chk("u2_frame_done_width", fd2, 0);
    chk("u2_frame1_drained", q2.size(), 0);

    // Second clear mid-frame; the following full frame is all spaces
    c2 = 1; @(negedge clk); c2 = 0;
    for (int i = 0; i < 32; i++) m2[i] = 8'h20;
    n = 0;
    while (!rdy2 && n < 100) begin n++; @(negedge clk); end
    chk("u2_clear2_ready_low", n, 32);
    n = 0; do begin @(negedge clk); n++; end while (!fd2 && n < 2000);
    chk("u2_frame_period", cyc - t, 1360);
    t = cyc;
    push_frame(0, 2, 16);
    n = 0; do begin @(negedge clk); n++; end while (!fd2 && n < 2000);
    chk("u2_frame_period2", cyc - t, 1360);
    @(negedge clk);
    chk("u2_frame3_drained", q2.size(), 0);

    // Reset while characters are being sent
    n = 0; do begin @(negedge clk); n++; end while (!(en2 && rs2) && n < 400);
    chk("u2_reach_char", en2 && rs2, 1);
    rst = 1;
    @(negedge clk);
    chk("midrst_lcd_en", en2, 0);
    chk("midrst_init_done", id2, 0);
    chk("midrst_lcd_data", lcd2, 0);
    chk("midrst_lcd_rs", rs2, 0);
    rst = 0; rel = cyc;
    push_init(0, 2);
    n = 0; do begin @(negedge clk); n++; end while (!en2 && n < 300);
    chk("u2_reinit_first_en", cyc - rel, 130);
    n = 0; do begin @(negedge clk); n++; end while (!id2 && n < 500);
    chk("u2_reinit_done_cycle", cyc - rel, 380);
    chk("u2_reinit_drained", q2.size(), 0);

    // 4x20 and 1x16 geometries
    rst_b = 0; rel = cyc;
    c4 = 1; c1 = 1;
    @(negedge clk); c4 = 0; c1 = 0;
    for (int i = 0; i < 80; i++) m4[i] = 8'h20;
    for (int i = 0; i < 16; i++) m1[i] = 8'h20;
    n = 0;
    while (!rdy4 && n < 200) begin n++; @(negedge clk); end
    chk("u4_clear_ready_low", n, 80);
    wr4(0, 0, 8'h41);  m4[0]  = 8'h41;
    wr4(3, 19, 8'h7A); m4[79] = 8'h7A;
    wr1(0, 0, 8'h31);  m1[0]  = 8'h31;
    wr1(1, 0, 8'h39);
    wr1(0, 15, 8'h7E); m1[15] = 8'h7E;
    push_init(1, 4); push_frame(1, 4, 20);
    push_init(2, 1); push_frame(2, 1, 16);

    // Overwrite the first cell between its high and low nibble
    n = 0; do begin @(negedge clk); n++; end while (!(en4 && rs4) && n < 1000);
    chk("u4_reach_char", en4 && rs4, 1);
    wr4(0, 0, 8'h5B); m4[0] = 8'h5B;
    n = 0; do begin @(negedge clk); n++; end while (!fd4 && n < 5000);
    chk("u4_frame1_cycle", cyc - rel, 3740);
    t = cyc;
    push_frame(1, 4, 20);
    n = 0; do begin @(negedge clk); n++; end while (!fd4 && n < 5000);
    chk("u4_frame_period", cyc - t, 3360);
    @(negedge clk);
    chk("u4_drained", q4.size(), 0);
    chk("u1_drained", q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
